button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Front-end for the board push-buttons, directly upstream of the LCD menu/state sequencer. Synchronises and debounces N raw button inputs. Produces clean levels (bit 0 drives the sequencer's CENTER_BUTTON) plus single-cycle short-press, long-press and auto-repeat event pulses for menu navigation (time set, timezone select). Runs on the same 1 kHz tick clock as the LCD sequencer, so 1 cycle = 1 ms.

Parameters:
N_BTN, 5, number of button channels (bit 0 = CENTER, 1 = UP, 2 = DOWN, 3 = LEFT, 4 = RIGHT)
DEBOUNCE_CYC, 20, consecutive stable cycles required to accept a level change (>=1)
LONG_CYC, 1000, cycles held before a long-press event (> DEBOUNCE_CYC)
REPEAT_DELAY, 500, cycles held before the first auto-repeat pulse
REPEAT_CYC, 100, cycles between subsequent auto-repeat pulses (>=1)
CNT_W, 11, hold/debounce counter width; must represent max(LONG_CYC, REPEAT_DELAY+REPEAT_CYC)

Ports:
CLK  in  1  system tick clock, all logic on rising edge
RESETN  in  1  reset, synchronous, active-low
BTN_RAW  in  N_BTN  asynchronous raw button inputs, 1 = pressed
BTN_LEVEL  out  N_BTN  debounced level, 1 = pressed; BTN_LEVEL[0] feeds CENTER_BUTTON
BTN_PRESS  out  N_BTN  1-cycle pulse on release of a short press (held < LONG_CYC)
BTN_LONG  out  N_BTN  1-cycle pulse when hold reaches LONG_CYC
BTN_REPEAT  out  N_BTN  1-cycle auto-repeat pulses while held (see Optional Feature)

Behaviour:
- Single clock CLK; reset is synchronous, active-low on RESETN: while RESETN=0 at a rising edge, the sync flops, levels, counters and FSMs clear. All outputs = 0; FSM = IDLE.
- Per channel, fully independent; simultaneous presses on several channels are handled in parallel with no priority.
- Sync: 2-flop synchroniser on each BTN_RAW bit, reset value 0.
- Debounce: deb_cnt increments while synced input != BTN_LEVEL, and clears to 0 whenever they agree. When deb_cnt reaches DEBOUNCE_CYC-1 and still differs, BTN_LEVEL toggles and deb_cnt clears. Latency, clean edge to BTN_LEVEL: 2 + DEBOUNCE_CYC cycles. Glitches shorter than DEBOUNCE_CYC cycles are fully rejected.
- Hold counter hold_cnt: cleared on every BTN_LEVEL 0->1 transition. Increments each cycle while BTN_LEVEL=1. Saturates at 2^CNT_W-1; it never wraps.
- FSM per channel:
  - IDLE: on BTN_LEVEL rising -> PRESSED.
  - PRESSED: hold_cnt == LONG_CYC-1 -> assert BTN_LONG for exactly 1 cycle, go to HELD. Level falling -> assert BTN_PRESS for 1 cycle (the cycle after BTN_LEVEL falls), go to IDLE.
  - HELD: level falling -> IDLE, with no BTN_PRESS.
- Long pulse timing: BTN_LONG is high in the LONG_CYC-th cycle of BTN_LEVEL=1, counting the rising cycle as cycle 1.
- Release on the exact cycle that LONG would fire: LONG takes priority; BTN_PRESS is not emitted.
- Reset mid-press: everything clears. A button still physically held is re-detected as a new press after 2 + DEBOUNCE_CYC cycles.
- BTN_PRESS, BTN_LONG and BTN_REPEAT are registered outputs, never high for more than 1 consecutive cycle per event.

Optional Feature:
Macro BUTTON_AUTOREPEAT_EN.
- Defined: while BTN_LEVEL=1, BTN_REPEAT pulses when hold_cnt == REPEAT_DELAY-1, then every REPEAT_CYC cycles until release. This works in both PRESSED and HELD; the saturated counter is not used for repeat timing (a separate repeat counter wraps at REPEAT_CYC).
- Not defined: BTN_REPEAT is tied to 0 and the repeat counter logic is absent.

Decomposition:
- Package btn_pkg:
  - FSM state encoding IDLE/PRESSED/HELD (2 bits).
  - Button index constants BTN_CENTER=0, BTN_UP=1, BTN_DOWN=2, BTN_LEFT=3, BTN_RIGHT=4.
  - Default timing constants.
- Sub-module btn_channel: sync + debounce + FSM for one button, instantiated N_BTN times by a generate loop in button_conditioner.

Test Plan:
- Reset: RESETN=0 for 3 cycles with BTN_RAW=5'b11111 -> all outputs 0. After release, BTN_LEVEL=5'b11111 exactly 22 cycles later (defaults).
- Glitch rejection: BTN_RAW[0] high for 19 cycles then low -> BTN_LEVEL[0], BTN_PRESS[0], BTN_LONG[0] stay 0.
- Short press: BTN_RAW[1] high 200 cycles -> BTN_LEVEL[1] high 200 cycles. Single BTN_PRESS[1] pulse the cycle after the level falls; no BTN_LONG.
- Long press: BTN_RAW[0] high 1500 cycles -> BTN_LONG[0] pulse in the 1000th level-high cycle. No BTN_PRESS on release; CENTER level high continuously.
- Auto-repeat (macro defined): hold BTN_RAW[2] 800 cycles -> BTN_REPEAT[2] pulses at level cycles 500, 600, 700, 800. Macro undefined: never any pulse.
- Simultaneous/boundary: BTN_RAW[3] and [4] rise together; [3] released at level cycle 1000 -> BTN_LONG[3] only, no BTN_PRESS[3]. [4] released at cycle 50 -> BTN_PRESS[4]. Assert RESETN=0 mid-hold -> all outputs clear next edge.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM encoding, button indices and default timing for the button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_e;

    localparam int BTN_CENTER = 0;
    localparam int BTN_UP     = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_RIGHT  = 4;

    localparam int DEF_N_BTN        = 5;
    localparam int DEF_DEBOUNCE_CYC = 20;
    localparam int DEF_LONG_CYC     = 1000;
    localparam int DEF_REPEAT_DELAY = 500;
    localparam int DEF_REPEAT_CYC   = 100;
    localparam int DEF_CNT_W        = 11;

    // Largest hold value the counters must be able to represent.
    function automatic int cnt_need(input int long_cyc, input int rep_delay, input int rep_cyc);
        return (long_cyc > rep_delay + rep_cyc) ? long_cyc : rep_delay + rep_cyc;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: sync, debounce, hold timing and press/long/repeat FSM for one button.
//   i_clk      tick clock (1 ms), rising edge
//   i_rst_n    synchronous active-low reset
//   i_raw      asynchronous raw button, 1 = pressed
//   o_level    debounced level
//   o_press    1-cycle pulse after release of a short press
//   o_long     1-cycle pulse in the LONG_CYC-th level-high cycle
//   o_repeat   1-cycle auto-repeat pulses (BUTTON_AUTOREPEAT_EN), else 0
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter int CNT_W        = DEF_CNT_W
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC
`endif
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_long,
    output logic o_repeat
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    // Outputs are registered, so the decision is taken one cycle early.
    localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CYC - 2);
    localparam logic [CNT_W-1:0] HOLD_MAX = '1;

    logic             r_s1, r_s2, r_level, r_press, r_long;
    logic [CNT_W-1:0] r_deb, r_hold;
    btn_state_e       r_state;
    logic             w_differ, w_deb_done, w_level_nxt, w_long_hit;

    assign w_differ    = r_s2 != r_level;
    assign w_deb_done  = w_differ && r_deb == DEB_LAST;
    assign w_level_nxt = w_deb_done ? ~r_level : r_level;
    assign w_long_hit  = r_level && r_hold == LONG_PRE;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_deb   <= '0;
            r_level <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_deb   <= (w_differ && !w_deb_done) ? r_deb + 1'b1 : '0;
            r_level <= w_level_nxt;
            if (w_level_nxt && !r_level)
                r_hold <= '0;
            else if (r_level && r_hold != HOLD_MAX)
                r_hold <= r_hold + 1'b1;
        end
    end

    // A release in the cycle the long pulse is issued still yields LONG only,
    // because the FSM has already moved to HELD.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_press <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            r_long  <= 1'b0;
            case (r_state)
                IDLE: if (r_level) begin
                    r_state <= w_long_hit ? HELD : PRESSED;
                    r_long  <= w_long_hit;
                end
                PRESSED: if (w_long_hit) begin
                    r_state <= HELD;
                    r_long  <= 1'b1;
                end else if (!r_level) begin
                    r_state <= IDLE;
                    r_press <= 1'b1;
                end
                HELD: if (!r_level) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;
    assign o_long  = r_long;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_PRE  = CNT_W'(REPEAT_DELAY - 2);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);

    logic             r_rep_arm, r_repeat;
    logic [CNT_W-1:0] r_rep_cnt;

    // First pulse keys off the hold counter; later pulses use a private
    // wrapping counter so saturation of r_hold cannot stall them.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rep_arm <= 1'b0;
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (!r_level || !w_level_nxt) begin
                r_rep_arm <= 1'b0;
                r_rep_cnt <= '0;
            end else if (!r_rep_arm && r_hold == REP_PRE) begin
                r_rep_arm <= 1'b1;
                r_rep_cnt <= '0;
                r_repeat  <= 1'b1;
            end else if (r_rep_arm) begin
                r_rep_cnt <= (r_rep_cnt == REP_LAST) ? '0 : r_rep_cnt + 1'b1;
                r_repeat  <= r_rep_cnt == REP_LAST;
            end
        end
    end

    assign o_repeat = r_repeat;
`else
    assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N-channel push-button synchroniser/debouncer with press, long and repeat events.
//   CLK         1 kHz tick clock, rising edge
//   RESETN      synchronous active-low reset
//   BTN_RAW     raw buttons (bit 0 CENTER, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT)
//   BTN_LEVEL   debounced levels; bit 0 drives CENTER_BUTTON
//   BTN_PRESS   short-press pulse after release
//   BTN_LONG    long-press pulse at LONG_CYC held cycles
//   BTN_REPEAT  auto-repeat pulses, only when BUTTON_AUTOREPEAT_EN is defined
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN        = DEF_N_BTN,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [N_BTN-1:0] BTN_RAW,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_LONG,
    output logic [N_BTN-1:0] BTN_REPEAT
);

    if (cnt_need(LONG_CYC, REPEAT_DELAY, REPEAT_CYC) > 2**CNT_W - 1 || LONG_CYC <= DEBOUNCE_CYC ||
        DEBOUNCE_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_cfg
        $error("button_conditioner: illegal timing parameters");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC),
            .CNT_W       (CNT_W)
`ifdef BUTTON_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_CYC  (REPEAT_CYC)
`endif
        ) u_ch (
            .i_clk   (CLK),
            .i_rst_n (RESETN),
            .i_raw   (BTN_RAW[i]),
            .o_level (BTN_LEVEL[i]),
            .o_press (BTN_PRESS[i]),
            .o_long  (BTN_LONG[i]),
            .o_repeat(BTN_REPEAT[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed self-checking bench for button_conditioner at default timing.
module tb_button_conditioner;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [4:0] BTN_RAW, BTN_LEVEL, BTN_PRESS, BTN_LONG, BTN_REPEAT;

    int asserts = 0, fails = 0, cyc;
    int dur[5];
    int lvl_n[5], lvl_first[5], lvl_last[5], prs_n[5], prs_at[5], lng_n[5], lng_at[5], rep_n[5];
    int rep_at[5][8];

    always #5 CLK = ~CLK;

    button_conditioner dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .BTN_RAW   (BTN_RAW),
        .BTN_LEVEL (BTN_LEVEL),
        .BTN_PRESS (BTN_PRESS),
        .BTN_LONG  (BTN_LONG),
        .BTN_REPEAT(BTN_REPEAT)
    );

    task automatic clear_stats;
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            lvl_n[i] = 0; lvl_first[i] = -1; lvl_last[i] = -1;
            prs_n[i] = 0; prs_at[i] = -1; lng_n[i] = 0; lng_at[i] = -1; rep_n[i] = 0;
            for (int k = 0; k < 8; k++) rep_at[i][k] = -1;
        end
    endtask

    // Advance one clock and record what the outputs show after that edge.
    task automatic step;
        @(negedge CLK);
        cyc++;
        for (int i = 0; i < 5; i++) begin
            if (BTN_LEVEL[i]) begin
                if (lvl_n[i] == 0) lvl_first[i] = cyc;
                lvl_last[i] = cyc;
                lvl_n[i]++;
            end
            if (BTN_PRESS[i]) begin prs_at[i] = cyc; prs_n[i]++; end
            if (BTN_LONG[i]) begin lng_at[i] = cyc; lng_n[i]++; end
            if (BTN_REPEAT[i]) begin
                if (rep_n[i] < 8) rep_at[i][rep_n[i]] = cyc;
                rep_n[i]++;
            end
        end
    endtask

    // Button i is held for dur[i] cycles starting at cycle 0.
    task automatic run_press(input int total);
        clear_stats();
        for (int c = 0; c < total; c++) begin
            for (int i = 0; i < 5; i++) BTN_RAW[i] = c < dur[i];
            step();
        end
        BTN_RAW = '0;
        for (int i = 0; i < 5; i++) dur[i] = 0;
    endtask

    task automatic test_reset;
        RESETN = 1'b0;
        BTN_RAW = 5'b11111;
        for (int c = 0; c < 3; c++) begin
            step();
            asserts++;
            if ({BTN_LEVEL, BTN_PRESS, BTN_LONG, BTN_REPEAT} !== 20'h0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, {BTN_LEVEL, BTN_PRESS, BTN_LONG, BTN_REPEAT});
            end
        end
        RESETN = 1'b1;
        clear_stats();
        repeat (21) step();
        asserts++;
        if (BTN_LEVEL !== 5'b00000) begin fails++; $display("FAIL reset_level_21: got %b expected 00000", BTN_LEVEL); end
        step();
        asserts++;
        if (BTN_LEVEL !== 5'b11111) begin fails++; $display("FAIL reset_level_22: got %b expected 11111", BTN_LEVEL); end
        BTN_RAW = '0;
        RESETN = 1'b0;
        repeat (2) step();
        RESETN = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_glitch;
        dur[0] = 19;
        run_press(80);
        asserts++;
        if (lvl_n[0] !== 0) begin fails++; $display("FAIL glitch_level: got %0d high cycles expected 0", lvl_n[0]); end
        asserts++;
        if (prs_n[0] + lng_n[0] !== 0) begin fails++; $display("FAIL glitch_events: got %0d expected 0", prs_n[0] + lng_n[0]); end
    endtask

    task automatic test_debounce_edge;
        dur[0] = 20;
        run_press(80);
        asserts++;
        if (lvl_n[0] !== 20 || lvl_first[0] !== 22) begin
            fails++; $display("FAIL deb_edge_level: got n=%0d first=%0d expected n=20 first=22", lvl_n[0], lvl_first[0]);
        end
        asserts++;
        if (prs_n[0] !== 1 || prs_at[0] !== 43) begin
            fails++; $display("FAIL deb_edge_press: got n=%0d at=%0d expected n=1 at=43", prs_n[0], prs_at[0]);
        end
    endtask

    task automatic test_short_press;
        dur[1] = 200;
        run_press(260);
        asserts++;
        if (lvl_n[1] !== 200 || lvl_first[1] !== 22 || lvl_last[1] !== 221) begin
            fails++; $display("FAIL short_level: got n=%0d %0d..%0d expected n=200 22..221", lvl_n[1], lvl_first[1], lvl_last[1]);
        end
        asserts++;
        if (prs_n[1] !== 1 || prs_at[1] !== 223) begin
            fails++; $display("FAIL short_press: got n=%0d at=%0d expected n=1 at=223", prs_n[1], prs_at[1]);
        end
        asserts++;
        if (lng_n[1] !== 0) begin fails++; $display("FAIL short_no_long: got %0d expected 0", lng_n[1]); end
    endtask

    task automatic test_long_press;
        dur[0] = 1500;
        run_press(1560);
        asserts++;
        if (lvl_n[0] !== 1500 || lvl_last[0] - lvl_first[0] + 1 !== 1500) begin
            fails++; $display("FAIL long_level: got n=%0d %0d..%0d expected 1500 contiguous", lvl_n[0], lvl_first[0], lvl_last[0]);
        end
        asserts++;
        if (lng_n[0] !== 1 || lng_at[0] !== 1021) begin
            fails++; $display("FAIL long_pulse: got n=%0d at=%0d expected n=1 at=1021", lng_n[0], lng_at[0]);
        end
        asserts++;
        if (prs_n[0] !== 0) begin fails++; $display("FAIL long_no_press: got %0d expected 0", prs_n[0]); end
    endtask

    task automatic test_repeat;
        dur[2] = 800;
        run_press(860);
`ifdef BUTTON_AUTOREPEAT_EN
        asserts++;
        if (rep_n[2] !== 4) begin fails++; $display("FAIL repeat_count: got %0d expected 4", rep_n[2]); end
        for (int k = 0; k < 4; k++) begin
            asserts++;
            if (rep_at[2][k] !== 521 + 100 * k) begin
                fails++; $display("FAIL repeat_pos%0d: got %0d expected %0d", k, rep_at[2][k], 521 + 100 * k);
            end
        end
`else
        asserts++;
        if (rep_n[2] !== 0) begin fails++; $display("FAIL repeat_disabled: got %0d expected 0", rep_n[2]); end
`endif
        asserts++;
        if (prs_n[2] !== 1 || prs_at[2] !== 823) begin
            fails++; $display("FAIL repeat_press: got n=%0d at=%0d expected n=1 at=823", prs_n[2], prs_at[2]);
        end
    endtask

    task automatic test_simultaneous;
        dur[3] = 1000;
        dur[4] = 50;
        run_press(1060);
        asserts++;
        if (lvl_first[3] !== 22 || lvl_first[4] !== 22) begin
            fails++; $display("FAIL simul_rise: got %0d/%0d expected 22/22", lvl_first[3], lvl_first[4]);
        end
        asserts++;
        if (lng_n[3] !== 1 || lng_at[3] !== 1021 || prs_n[3] !== 0) begin
            fails++; $display("FAIL simul_long3: got long n=%0d at=%0d press=%0d expected 1 at 1021, press 0", lng_n[3], lng_at[3], prs_n[3]);
        end
        asserts++;
        if (prs_n[4] !== 1 || prs_at[4] !== 73 || lng_n[4] !== 0) begin
            fails++; $display("FAIL simul_press4: got press n=%0d at=%0d long=%0d expected 1 at 73, long 0", prs_n[4], prs_at[4], lng_n[4]);
        end
    endtask

    task automatic test_reset_mid_hold;
        clear_stats();
        BTN_RAW = 5'b00011;
        repeat (600) step();
        asserts++;
        if (BTN_LEVEL !== 5'b00011) begin fails++; $display("FAIL midhold_level: got %b expected 00011", BTN_LEVEL); end
        RESETN = 1'b0;
        step();
        asserts++;
        if ({BTN_LEVEL, BTN_PRESS, BTN_LONG, BTN_REPEAT} !== 20'h0) begin
            fails++; $display("FAIL midhold_reset: got %h expected 0", {BTN_LEVEL, BTN_PRESS, BTN_LONG, BTN_REPEAT});
        end
        step();
        RESETN = 1'b1;
        repeat (21) step();
        asserts++;
        if (BTN_LEVEL !== 5'b00000) begin fails++; $display("FAIL redetect_21: got %b expected 00000", BTN_LEVEL); end
        step();
        asserts++;
        if (BTN_LEVEL !== 5'b00011) begin fails++; $display("FAIL redetect_22: got %b expected 00011", BTN_LEVEL); end
        BTN_RAW = '0;
        repeat (40) step();
    endtask

    initial begin
        for (int i = 0; i < 5; i++) dur[i] = 0;
        test_reset();
        test_glitch();
        test_debounce_edge();
        test_short_press();
        test_long_press();
        test_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
